// File: rtl/ysyx_23060184_mem_responder.sv
// ysyx_23060184_mem_responder
// Registered, multi-cycle word memory slave for the SGC core memory port.
// One request outstanding at a time: IDLE accepts, BUSY counts down the
// access latency, RESP holds the response until the requester takes it.
// The access (write commit / read capture) happens on the edge that enters
// RESP, so read data and the written word are both visible together.
//
// Optional feature: define YSYX_23060184_MEM_RAND_DELAY_EN to add 0..7
// pseudo-random wait cycles per request (16-bit LFSR, taps 16,15,13,4),
// used to shake out handshake bugs in the core.
module ysyx_23060184_mem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  logic [31:0] mem [0:DEPTH-1];

  // Effective per-request latency (base plus optional random extra)
  logic [4:0] lat;

`ifdef YSYX_23060184_MEM_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
  assign lat     = 5'(LATENCY) + {2'b00, lfsr[2:0]};

  // LFSR steps once per accepted request so each request draws a new delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= 16'hACE1;
    else if (state == IDLE && req_valid)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign lat = 5'(LATENCY);
`endif

  // Access source: zero-latency requests use the live request, otherwise
  // the copy latched at acceptance.
  logic        direct;
  logic        fire;
  logic        acc_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wmask;
  logic [31:0] acc_off;
  logic [31:0] acc_idx;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] rdata_nxt;

  assign direct    = (state == IDLE) && req_valid && (lat == 5'd0);
  assign fire      = direct || (state == BUSY && cnt == 5'd1);
  assign acc_wen   = direct ? req_wen   : wen_q;
  assign acc_addr  = direct ? req_addr  : addr_q;
  assign acc_wdata = direct ? req_wdata : wdata_q;
  assign acc_wmask = direct ? req_wmask : wmask_q;

  // Word index uses 32-bit wrap so addresses below BASE_ADDR land far out
  // of range instead of aliasing onto low words.
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_idx   = acc_off >> 2;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_idx >= 32'(DEPTH));
  assign rd_word   = mem[acc_idx[DEPTH_LOG2-1:0]];
  assign rdata_nxt = (acc_err || acc_wen) ? 32'h0 : rd_word;

  // Byte-lane write commit; contents are deliberately not reset, and an
  // access coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && fire && acc_wen && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i])
          mem[acc_idx[DEPTH_LOG2-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q     <= req_wen;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            req_ready <= 1'b0;
            if (lat == 5'd0) begin
              state      <= RESP;
              cnt        <= 5'd0;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_nxt;
              resp_err   <= acc_err;
            end else begin
              state <= BUSY;
              cnt   <= lat;
            end
          end
        end
        BUSY: begin
          if (cnt == 5'd1) begin
            state      <= RESP;
            cnt        <= 5'd0;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_nxt;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 5'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_mem_responder.sv
// Directed bench for ysyx_23060184_mem_responder (LATENCY=3, 4K words).
module tb_ysyx_23060184_mem_responder;

  localparam int LAT = 3;
`ifdef YSYX_23060184_MEM_RAND_DELAY_EN
  localparam int LAT_HI = LAT + 7;
`else
  localparam int LAT_HI = LAT;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  ysyx_23060184_mem_responder #(
    .DEPTH_LOG2(12),
    .LATENCY   (LAT),
    .BASE_ADDR (32'h8000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters for the one-response-per-request check
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready)   acc_cnt <= acc_cnt + 1;
    if (!reset && resp_valid && resp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  // Drives one full transaction starting at a negedge and returns at a
  // negedge with the FSM back in IDLE. edges = posedges from the accept
  // edge (inclusive) until resp_valid is seen.
  task automatic do_txn(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output logic err,
                        output int edges);
    int n;
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_wmask = mask;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && edges < 60) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    rdata = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int e;
    do_txn(1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, rd, er, e);
    n_cmp++; if (e < LAT + 1 || e > LAT_HI + 1) begin n_bad++; $display("FAIL wr_latency: got %0d edges want %0d..%0d", e, LAT + 1, LAT_HI + 1); end
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL wr_resp: got %h err=%b want 0 err=0", rd, er); end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, e);
    n_cmp++; if (e < LAT + 1 || e > LAT_HI + 1) begin n_bad++; $display("FAIL rd_latency: got %0d edges want %0d..%0d", e, LAT + 1, LAT_HI + 1); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, er); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic er; int e;
    do_txn(1'b1, 32'h8000_0014, 32'h11223344, 4'hF, rd, er, e);
    do_txn(1'b1, 32'h8000_0014, 32'hAABBCCDD, 4'b0101, rd, er, e);
    do_txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, rd, er, e);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL mask_merge: got %h want 11bb33dd", rd); end
    do_txn(1'b1, 32'h8000_0014, 32'hFFFFFFFF, 4'b0000, rd, er, e);
    do_txn(1'b0, 32'h8000_0014, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin n_bad++; $display("FAIL mask_noop: got %h err=%b want 11bb33dd err=0", rd, er); end
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic er; int e;
    do_txn(1'b0, 32'h8000_0002, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_misaligned: got %h err=%b want 0 err=1", rd, er); end
    do_txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_below_base: got %h err=%b want 0 err=1", rd, er); end
    do_txn(1'b0, 32'h8000_4000, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_past_end: got err=%b want 1", er); end
    do_txn(1'b1, 32'h8000_3FFC, 32'h12345678, 4'hF, rd, er, e);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL last_word_ok: got err=%b want 0", er); end
    // Faulting writes that would alias onto words 4 and 4095 if unchecked
    do_txn(1'b1, 32'h8000_0012, 32'h0BAD0BAD, 4'hF, rd, er, e);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_wr_misaligned: got %h err=%b want 0 err=1", rd, er); end
    do_txn(1'b1, 32'h7FFF_FFFC, 32'h0BAD0BAD, 4'hF, rd, er, e);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL err_mem_kept_lo: got %h want deadbeef", rd); end
    do_txn(1'b0, 32'h8000_3FFC, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_bad++; $display("FAIL err_mem_kept_hi: got %h err=%b want 12345678 err=0", rd, er); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int e; int n;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!resp_valid && n < 60) begin @(negedge clk); n++; end
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_resp_timeout: got valid=%b want 1", resp_valid); end
    // Stray write presented while stalled must be ignored
    req_valid = 1'b1; req_wen = 1'b1; req_wdata = 32'h0; req_wmask = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h e=%b rdy=%b want 1/deadbeef/0/0", i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stall_ignored_wr: got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int e;
    do_txn(1'b1, 32'h8000_0020, 32'h01020304, 4'hF, rd, er, e);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 32'hCAFEF00D; req_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_async: got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle: got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    do_txn(1'b0, 32'h8000_0020, 32'h0, 4'hF, rd, er, e);
    n_cmp++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL midrst_dropped: got %h want 01020304", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int e; int a0; int r0;
    logic [31:0] pat [8];
    for (int k = 0; k < 8; k++) begin
      pat[k] = (32'h1000_0001 * (k + 1)) ^ 32'hF0F0_0000;
      do_txn(1'b1, 32'h8000_0100 + 32'(4 * k), pat[k], 4'hF, rd, er, e);
    end
    a0 = acc_cnt; r0 = rsp_cnt;
    for (int i = 0; i < 100; i++) begin
      do_txn(1'b0, 32'h8000_0100 + 32'(4 * (i % 8)), 32'h0, 4'hF, rd, er, e);
      n_cmp++; if (rd !== pat[i % 8] || er !== 1'b0) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h err=%b want %h err=0", i, rd, er, pat[i % 8]); end
      n_cmp++; if (e < LAT + 1 || e > LAT_HI + 1) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d edges want %0d..%0d", i, e, LAT + 1, LAT_HI + 1); end
    end
    n_cmp++; if (acc_cnt - a0 != 100 || rsp_cnt - r0 != 100) begin n_bad++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 100/100", acc_cnt - a0, rsp_cnt - r0); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wmask = 4'h0; resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_addr_err();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
